// File: rtl/sample_decimator.sv
// sample_decimator: averages each block of N = 2^LOG2_RATIO signed samples
// into one result. The input side is a valid/ready consumer and the output
// side is a valid/ready producer holding a single result register.
//
// Ports
//   clk         sole clock, rising edge
//   reset       asynchronous active-high reset
//   clear       synchronous discard of the partial block and any pending result
//   in_data     signed sample, DATA_WIDTH bits
//   in_valid    in_data is valid this cycle
//   in_ready    block accepts in_data this cycle (= !out_valid || out_ready)
//   out_data    signed block average (floor)
//   out_valid   out_data holds an unconsumed result
//   out_ready   downstream consumes out_data this cycle
//   sample_cnt  samples accumulated in the current block
//   block_cnt   results emitted since reset, wraps at 16 bits
module sample_decimator #(
  parameter int DATA_WIDTH = 16,
  parameter int LOG2_RATIO = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LOG2_RATIO-1:0] sample_cnt,
  output logic [15:0]           block_cnt
);

  // N samples of DATA_WIDTH bits sum into DATA_WIDTH+LOG2_RATIO bits without overflow.
  localparam int AW = DATA_WIDTH + LOG2_RATIO;

  typedef enum logic {ACCUM = 1'b0, FULL = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic signed [AW-1:0]    acc_q, acc_d, sum;
  logic [LOG2_RATIO-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   out_q, out_d, avg;
  logic [15:0]             block_cnt_q, block_cnt_d;
  logic                    in_xfer, out_xfer, last;

  assign out_valid  = (state_q == FULL);
  assign in_ready   = !out_valid || out_ready;
  assign in_xfer    = in_valid && in_ready;
  assign out_xfer   = out_valid && out_ready;
  assign last       = &cnt_q;
  assign out_data   = out_q;
  assign sample_cnt = cnt_q;
  assign block_cnt  = block_cnt_q;

  assign sum = acc_q + {{LOG2_RATIO{in_data[DATA_WIDTH-1]}}, in_data};
  // Dropping the low LOG2_RATIO bits of a two's complement value is an
  // arithmetic right shift, i.e. floor division by N.
  assign avg = sum[AW-1:LOG2_RATIO];

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    block_cnt_d = block_cnt_q;
    if (clear) begin
      state_d = ACCUM;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      // A drained result frees the register unless a new one lands this edge.
      if (out_xfer) state_d = ACCUM;
      if (in_xfer) begin
        if (last) begin
          state_d     = FULL;
          out_d       = avg;
          acc_d       = '0;
          cnt_d       = '0;
          block_cnt_d = block_cnt_q + 16'(1);
        end else begin
          acc_d = sum;
          cnt_d = cnt_q + LOG2_RATIO'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      block_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      block_cnt_q <= block_cnt_d;
    end
  end

endmodule

// File: tb/tb_sample_decimator.sv
module tb_sample_decimator;
  localparam int DW = 16;
  localparam int L  = 2;

  logic          clk = 1'b0;
  logic          reset, clear, in_valid, out_ready;
  logic [DW-1:0] in_data;
  logic          in_ready, out_valid;
  logic [DW-1:0] out_data;
  logic [L-1:0]  sample_cnt;
  logic [15:0]   block_cnt;

  sample_decimator #(.DATA_WIDTH(DW), .LOG2_RATIO(L)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .sample_cnt(sample_cnt), .block_cnt(block_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h @%0t", tag, act, exp, $time);
    end
  endtask

  // reference model: block sum, position in block, result counter
  int          macc = 0;
  int          mcnt = 0;
  logic [15:0] mblk = '0;
  logic [DW-1:0] exp_q[$];

  task automatic model_accept(input logic [DW-1:0] d);
    int s;
    logic [31:0] avg;
    macc += int'($signed(d));
    if (mcnt == (1 << L) - 1) begin
      s   = macc >>> L;
      avg = s;
      exp_q.push_back(avg[DW-1:0]);
      macc = 0;
      mcnt = 0;
      mblk++;
    end else mcnt++;
  endtask

  task automatic model_reset();
    macc = 0;
    mcnt = 0;
  endtask

  // output side of the scoreboard: a transfer happens at the next rising edge
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_out", {16'h0, out_data}, 32'hDEAD);
      else chk("out_data", {16'h0, out_data}, {16'h0, exp_q.pop_front()});
    end
  end

  // offer one sample, waiting (bounded) for acceptance; returns 1ns after the edge
  task automatic send(input logic [DW-1:0] d);
    int t = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      t++;
      @(negedge clk);
    end
    if (t >= 200) chk("in_timeout", 0, 1);
    else model_accept(d);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    #3;
    chk("rst_in_ready", {31'h0, in_ready}, 1);
    chk("rst_out_valid", {31'h0, out_valid}, 0);
    chk("rst_out_data", {16'h0, out_data}, 0);
    chk("rst_sample_cnt", {30'h0, sample_cnt}, 0);
    chk("rst_block_cnt", {16'h0, block_cnt}, 0);
    #14 reset = 1'b0;
    @(posedge clk); #1;

    // basic block, one-cycle pulse
    send(16'd1); send(16'd2); send(16'd3); send(16'd4);
    chk("b1_out_valid", {31'h0, out_valid}, 1);
    chk("b1_block_cnt", {16'h0, block_cnt}, {16'h0, mblk});
    @(posedge clk); #1;
    chk("b1_valid_drop", {31'h0, out_valid}, 0);

    // sign and extremes
    send(16'hFFFF); send(16'hFFFE); send(16'hFFFD); send(16'hFFFC);
    repeat (4) send(16'h7FFF);
    repeat (4) send(16'h8000);
    @(posedge clk); #1;

    // backpressure holds everything
    out_ready = 1'b0;
    send(16'd1); send(16'd2); send(16'd3); send(16'd4);
    in_valid = 1'b1; in_data = 16'd5;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", {31'h0, in_ready}, 0);
      chk("bp_sample_cnt", {30'h0, sample_cnt}, 0);
      chk("bp_out_data", {16'h0, out_data}, 16'd2);
      chk("bp_out_valid", {31'h0, out_valid}, 1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(16'd5); send(16'd6); send(16'd7); send(16'd8);
    @(posedge clk); #1;

    // continuous stream, full throughput
    for (int i = 0; i < 16; i++) begin
      send(16'(i));
      if (i >= 4 && (i % 4) == 3) chk("str_valid", {31'h0, out_valid}, 1);
    end
    chk("str_block_cnt", {16'h0, block_cnt}, {16'h0, mblk});
    @(posedge clk); #1;

    // clear discards the partial block and the offered sample
    send(16'd10); send(16'd20);
    clear = 1'b1; in_valid = 1'b1; in_data = 16'd99;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    model_reset();
    chk("clr_sample_cnt", {30'h0, sample_cnt}, 0);
    chk("clr_block_cnt", {16'h0, block_cnt}, {16'h0, mblk});
    repeat (4) send(16'd4);
    @(posedge clk); #1;
    @(posedge clk); #1;

    // asynchronous reset mid-block
    send(16'd10); send(16'd20);
    #2 reset = 1'b1;
    #1;
    chk("arst_sample_cnt", {30'h0, sample_cnt}, 0);
    chk("arst_block_cnt", {16'h0, block_cnt}, 0);
    chk("arst_out_valid", {31'h0, out_valid}, 0);
    chk("arst_in_ready", {31'h0, in_ready}, 1);
    #3 reset = 1'b0;
    model_reset();
    mblk = '0;
    @(posedge clk); #1;
    repeat (4) send(16'd4);
    chk("arst_b1_cnt", {16'h0, block_cnt}, 1);
    @(posedge clk); #1;

    // block counter wrap
    force dut.block_cnt_q = 16'hFFFE;
    #1 release dut.block_cnt_q;
    mblk = 16'hFFFE;
    @(posedge clk); #1;
    repeat (4) send(16'd7);
    chk("wrap_ffff", {16'h0, block_cnt}, {16'h0, mblk});
    repeat (4) send(16'd7);
    chk("wrap_zero", {16'h0, block_cnt}, 0);
    chk("wrap_model", {16'h0, mblk}, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1);
  end
endmodule
